// File: rtl/slti.sv
// slti: set-on-less-than-immediate for the 16-bit execute stage (SLTI / SLTIU).
// Latency: 1 cycle; rt/lt_flag/eq_flag/out_valid are all flop outputs.
// Backpressure: none; accepts one compare per cycle and never stalls.
//
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   in_valid        - launch a compare of rs against immediate this edge
//   unsigned_mode   - 0 = signed compare, 1 = unsigned compare
//   rs, immediate   - 16-bit operands A and B (immediate used as-is)
//   rt              - 16'h0001 when A < B, else 16'h0000
//   out_valid       - one-cycle strobe marking a fresh result
//   lt_flag         - copy of rt[0]
//   eq_flag         - A == B for the launched compare
module slti (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        unsigned_mode,
   input  logic [15:0] rs,
   input  logic [15:0] immediate,
   output logic [15:0] rt,
   output logic        out_valid,
   output logic        lt_flag,
   output logic        eq_flag
);

   logic [16:0] diff;
   logic [15:0] sum;
   logic        carry;
   logic        ovf;
   logic        lt;
   logic        eq;

   // A - B as A + ~B + 1; carry-out high means no borrow (A >= B unsigned).
   assign diff  = {1'b0, rs} + {1'b0, ~immediate} + 17'd1;
   assign sum   = diff[15:0];
   assign carry = diff[16];

   // Signed overflow: operands differ in sign and the result sign flipped away from A.
   assign ovf = (rs[15] != immediate[15]) && (sum[15] != rs[15]);

   assign lt = unsigned_mode ? ~carry : (sum[15] ^ ovf);
   assign eq = (sum == 16'h0000);

   always_ff @(posedge clk) begin
      if (reset) begin
         rt        <= 16'h0000;
         out_valid <= 1'b0;
         lt_flag   <= 1'b0;
         eq_flag   <= 1'b0;
      end else begin
         out_valid <= in_valid;
         // Results hold between compares so the consumer can read them late.
         if (in_valid) begin
            rt      <= {15'b0, lt};
            lt_flag <= lt;
            eq_flag <= eq;
         end
      end
   end

endmodule

// File: tb/tb_slti.sv
// tb_slti: directed and random checks of slti against an independent
// less-than model built on native signed/unsigned comparison.
module tb_slti;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        unsigned_mode;
   logic [15:0] rs;
   logic [15:0] immediate;
   logic [15:0] rt;
   logic        out_valid;
   logic        lt_flag;
   logic        eq_flag;

   int tests;
   int fails;

   slti dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .unsigned_mode (unsigned_mode),
      .rs            (rs),
      .immediate     (immediate),
      .rt            (rt),
      .out_valid     (out_valid),
      .lt_flag       (lt_flag),
      .eq_flag       (eq_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle away from it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic mode);
      in_valid      = 1'b1;
      rs            = a;
      immediate     = b;
      unsigned_mode = mode;
   endtask

   task automatic launch_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic mode, input logic [15:0] exp_rt);
      launch(a, b, mode);
      tick();
      check({tag, ".rt"}, rt, exp_rt);
      check({tag, ".vld"}, {15'b0, out_valid}, 16'h0001);
      check({tag, ".lt"}, {15'b0, lt_flag}, exp_rt);
   endtask

   function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b, input logic mode);
      logic r;
      if (mode) r = (a < b);
      else      r = ($signed(a) < $signed(b));
      return {15'b0, r};
   endfunction

   initial begin
      logic [15:0] a;
      logic [15:0] b;
      logic        m;
      tests = 0;
      fails = 0;
      reset = 1'b1;
      in_valid = 1'b0;
      unsigned_mode = 1'b0;
      rs = 16'h0000;
      immediate = 16'h0000;
      tick();
      tick();
      check("rst.rt", rt, 16'h0000);
      check("rst.vld", {15'b0, out_valid}, 16'h0000);
      check("rst.lt", {15'b0, lt_flag}, 16'h0000);
      check("rst.eq", {15'b0, eq_flag}, 16'h0000);
      reset = 1'b0;
      tick();
      check("idle.vld", {15'b0, out_valid}, 16'h0000);

      // Equal and greater, signed.
      launch_check("s10_10", 16'd10, 16'd10, 1'b0, 16'h0000);
      check("s10_10.eq", {15'b0, eq_flag}, 16'h0001);
      launch_check("s10_1", 16'd10, 16'd1, 1'b0, 16'h0000);
      check("s10_1.eq", {15'b0, eq_flag}, 16'h0000);

      // Back-to-back stream.
      launch_check("s10_11", 16'd10, 16'd11, 1'b0, 16'h0001);
      launch_check("s10_5", 16'd10, 16'd5, 1'b0, 16'h0000);
      launch_check("s0_1", 16'd0, 16'd1, 1'b0, 16'h0001);

      // Sign handling.
      launch_check("sFFFF_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0001);
      launch_check("uFFFF_1", 16'hFFFF, 16'h0001, 1'b1, 16'h0000);

      // Overflow corners.
      launch_check("s8000_7FFF", 16'h8000, 16'h7FFF, 1'b0, 16'h0001);
      launch_check("s7FFF_8000", 16'h7FFF, 16'h8000, 1'b0, 16'h0000);
      launch_check("u8000_7FFF", 16'h8000, 16'h7FFF, 1'b1, 16'h0000);
      launch_check("u7FFF_8000", 16'h7FFF, 16'h8000, 1'b1, 16'h0001);
      launch_check("u5_5", 16'h0005, 16'h0005, 1'b1, 16'h0000);
      check("u5_5.eq", {15'b0, eq_flag}, 16'h0001);

      // Hold while idle.
      launch_check("hold0_1", 16'd0, 16'd1, 1'b0, 16'h0001);
      in_valid = 1'b0;
      rs = 16'hFFFF;
      immediate = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold.rt", rt, 16'h0001);
         check("hold.vld", {15'b0, out_valid}, 16'h0000);
         check("hold.lt", {15'b0, lt_flag}, 16'h0001);
      end

      // Reset beats a simultaneous launch.
      reset = 1'b1;
      launch(16'd0, 16'd1, 1'b0);
      tick();
      check("rstv.rt", rt, 16'h0000);
      check("rstv.vld", {15'b0, out_valid}, 16'h0000);
      check("rstv.lt", {15'b0, lt_flag}, 16'h0000);
      reset = 1'b0;
      in_valid = 1'b0;
      tick();
      check("post.vld", {15'b0, out_valid}, 16'h0000);
      check("post.rt", rt, 16'h0000);
      launch_check("fresh", 16'd3, 16'd4, 1'b1, 16'h0001);

      // Random back-to-back compares.
      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         m = 1'($urandom);
         launch(a, b, m);
         tick();
         check("rnd.rt", rt, model(a, b, m));
         check("rnd.vld", {15'b0, out_valid}, 16'h0001);
         check("rnd.eq", {15'b0, eq_flag}, {15'b0, (a == b)});
      end

      in_valid = 1'b0;
      tick();
      check("end.vld", {15'b0, out_valid}, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
